// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request, ALU and response signal bundle for alu_share_arbiter
//
// Purpose: groups the two requester channels, the shared-ALU drive/return
// signals and the tagged response channel.
// Modports:
//   slave  - arbiter side (accepts requests, drives the ALU, produces responses)
//   master - environment side (requesters, ALU, response consumer)
interface alu_share_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [2:0]        req0_ctrl;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [2:0]        req1_ctrl;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic [2:0]        alu_control;
  logic [DATA_W-1:0] alu_dato1;
  logic [DATA_W-1:0] alu_dato2;
  logic [DATA_W-1:0] alu_exit;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_zero;
  logic              rsp_err;

  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b,
    input  req1_valid, req1_ctrl, req1_a, req1_b,
    input  alu_exit, rsp_ready,
    output req0_ready, req1_ready,
    output alu_control, alu_dato1, alu_dato2,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err
  );

  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b,
    output req1_valid, req1_ctrl, req1_a, req1_b,
    output alu_exit, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_control, alu_dato1, alu_dato2,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
//
// Purpose: accepts one operation at a time from req0/req1 (round robin on
// ties), drives the shared ALU with it, captures the result and returns it on
// a tagged valid/ready response channel. Illegal control codes (100/101) are
// answered with an error response without touching the ALU.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   bus      - alu_share_arbiter_if.slave (requests, ALU drive/return, response)
//   perf_clr, perf_grant0, perf_grant1 - grant counters, only with ALU_ARB_PERF_EN
// Optional feature macro: ALU_ARB_PERF_EN
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int PERF_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus
`ifdef ALU_ARB_PERF_EN
  ,
  input  logic                perf_clr,
  output logic [PERF_W-1:0]   perf_grant0,
  output logic [PERF_W-1:0]   perf_grant1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CAPT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic              r_last_grant;
  logic [2:0]        r_ctrl;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic              r_id;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_zero;
  logic              r_rsp_err;

  logic              w_grant_any;
  logic              w_grant_id;
  logic [2:0]        w_sel_ctrl;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic              w_sel_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_grant_any     = 1'b0;
    w_grant_id      = 1'b0;
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.alu_control = 3'b000;
    bus.alu_dato1   = '0;
    bus.alu_dato2   = '0;
    bus.rsp_valid   = 1'b0;

    // Tie goes to the port that did not win last time.
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant_id = ~r_last_grant;
    end else begin
      w_grant_id = bus.req1_valid;
    end
    w_sel_ctrl    = w_grant_id ? bus.req1_ctrl : bus.req0_ctrl;
    w_sel_a       = w_grant_id ? bus.req1_a    : bus.req0_a;
    w_sel_b       = w_grant_id ? bus.req1_b    : bus.req0_b;
    w_sel_illegal = (w_sel_ctrl[2:1] == 2'b10);

    case (r_state)
      S_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          w_grant_any    = 1'b1;
          bus.req0_ready = ~w_grant_id;
          bus.req1_ready = w_grant_id;
          // Illegal codes never reach the ALU; answer straight away.
          w_next_state   = w_sel_illegal ? S_RESP : S_EXEC;
        end
      end
      S_EXEC: begin
        bus.alu_control = r_ctrl;
        bus.alu_dato1   = r_a;
        bus.alu_dato2   = r_b;
        w_next_state    = S_CAPT;
      end
      S_CAPT: begin
        bus.alu_control = r_ctrl;
        bus.alu_dato1   = r_a;
        bus.alu_dato2   = r_b;
        w_next_state    = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_ctrl       <= 3'b000;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_grant_any) begin
        r_ctrl       <= w_sel_ctrl;
        r_a          <= w_sel_a;
        r_b          <= w_sel_b;
        r_id         <= w_grant_id;
        r_last_grant <= w_grant_id;
        if (w_sel_illegal) begin
          r_rsp_data <= '0;
          r_rsp_zero <= 1'b0;
          r_rsp_err  <= 1'b1;
        end
      end
      if (r_state == S_CAPT) begin
        r_rsp_data <= bus.alu_exit;
        r_rsp_zero <= (bus.alu_exit == '0);
        r_rsp_err  <= 1'b0;
      end
    end
  end

  assign bus.rsp_id   = r_id;
  assign bus.rsp_data = r_rsp_data;
  assign bus.rsp_zero = r_rsp_zero;
  assign bus.rsp_err  = r_rsp_err;

`ifdef ALU_ARB_PERF_EN
  logic [PERF_W-1:0] r_perf0;
  logic [PERF_W-1:0] r_perf1;

  // Saturating grant counters; clear wins over a same-cycle grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf0 <= '0;
      r_perf1 <= '0;
    end else if (perf_clr) begin
      r_perf0 <= '0;
      r_perf1 <= '0;
    end else begin
      if (bus.req0_ready && (r_perf0 != {PERF_W{1'b1}})) begin
        r_perf0 <= r_perf0 + PERF_W'(1);
      end
      if (bus.req1_ready && (r_perf1 != {PERF_W{1'b1}})) begin
        r_perf1 <= r_perf1 + PERF_W'(1);
      end
    end
  end

  assign perf_grant0 = r_perf0;
  assign perf_grant1 = r_perf1;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard testbench for alu_share_arbiter
module tb_alu_share_arbiter;

  localparam int DATA_W = 32;
  localparam int PERF_W = 4;

  logic clk;
  logic rst_n;

  alu_share_arbiter_if #(.DATA_W(DATA_W)) bus ();

`ifdef ALU_ARB_PERF_EN
  logic              perf_clr;
  logic [PERF_W-1:0] perf_grant0;
  logic [PERF_W-1:0] perf_grant1;
`endif

  alu_share_arbiter #(
    .DATA_W(DATA_W),
    .PERF_W(PERF_W)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus)
`ifdef ALU_ARB_PERF_EN
    ,
    .perf_clr   (perf_clr),
    .perf_grant0(perf_grant0),
    .perf_grant1(perf_grant1)
`endif
  );

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        zero;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  logic grant_log[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic m_busy = 1'b0;
  logic m_last = 1'b1;
  logic illegal_seen = 1'b0;

  function automatic logic [31:0] ref_alu(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b011:  return ~(a ^ b);
      3'b111:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // External combinational ALU.
  always_comb bus.alu_exit = ref_alu(bus.alu_control, bus.alu_dato1, bus.alu_dato2);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // Monitor: predicts grants, pushes expected responses, pops on handshake.
  initial begin
    logic        prev_v;
    logic        gid;
    logic        pred;
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (bus.alu_control == 3'b100 || bus.alu_control == 3'b101) illegal_seen = 1'b1;
        if (bus.req0_ready || bus.req1_ready) begin
          check("dual_grant", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
          check("grant_while_busy", {31'd0, m_busy}, 32'd0);
          if (bus.req0_valid && bus.req1_valid) pred = ~m_last;
          else pred = bus.req1_valid;
          gid = bus.req1_ready;
          check("grant_port", {31'd0, gid}, {31'd0, pred});
          c = gid ? bus.req1_ctrl : bus.req0_ctrl;
          a = gid ? bus.req1_a : bus.req0_a;
          b = gid ? bus.req1_b : bus.req0_b;
          e.id   = gid;
          e.err  = (c == 3'b100) || (c == 3'b101);
          e.data = e.err ? 32'd0 : ref_alu(c, a, b);
          e.zero = !e.err && (e.data == 32'd0);
          e.acc  = cyc;
          sb.push_back(e);
          grant_log.push_back(gid);
          m_last = gid;
          m_busy = 1'b1;
        end
        if (bus.rsp_valid && !prev_v) begin
          if (sb.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
          else check("latency", cyc - sb[0].acc, sb[0].err ? 32'd1 : 32'd3);
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (sb.size() == 0) begin
            check("rsp_without_op", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("rsp_id", {31'd0, bus.rsp_id}, {31'd0, e.id});
            check("rsp_data", bus.rsp_data, e.data);
            check("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, e.zero});
            check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
          end
          m_busy = 1'b0;
        end
        prev_v = bus.rsp_valid;
      end
    end
  end

  task automatic drive_req(input int p, input logic [2:0] c, input logic [31:0] a,
                           input logic [31:0] b);
    int   n;
    logic got;
    n   = 0;
    got = 1'b0;
    if (p == 0) begin
      bus.req0_valid = 1'b1; bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b;
    end
    while (!got && n < 300) begin
      @(negedge clk);
      got = (p == 0) ? bus.req0_ready : bus.req1_ready;
      n++;
    end
    if (!got) check("req_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (p == 0) bus.req0_valid = 1'b0;
    else bus.req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || m_busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("idle_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req0_ready"}, {31'd0, bus.req0_ready}, 32'd0);
    check({pfx, "_req1_ready"}, {31'd0, bus.req1_ready}, 32'd0);
    check({pfx, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({pfx, "_rsp_id"}, {31'd0, bus.rsp_id}, 32'd0);
    check({pfx, "_rsp_data"}, bus.rsp_data, 32'd0);
    check({pfx, "_rsp_zero"}, {31'd0, bus.rsp_zero}, 32'd0);
    check({pfx, "_rsp_err"}, {31'd0, bus.rsp_err}, 32'd0);
    check({pfx, "_alu_control"}, {29'd0, bus.alu_control}, 32'd0);
    check({pfx, "_alu_dato1"}, bus.alu_dato1, 32'd0);
    check({pfx, "_alu_dato2"}, bus.alu_dato2, 32'd0);
  endtask

  initial begin
    int   base;
    int   exp_order[4];
    logic stale;

    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_ctrl = 3'b000; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_ctrl = 3'b000; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready = 1'b1;
`ifdef ALU_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ADD on port 0.
    drive_req(0, 3'b010, 32'd5, 32'd7);
    wait_idle();

    // Illegal code on port 1, also leaves last_grant pointing at port 1.
    drive_req(1, 3'b101, 32'h1234, 32'h5678);
    wait_idle();

    // Both ports continuously valid: expect 0,1,0,1.
    base = grant_log.size();
    fork
      begin
        drive_req(0, 3'b110, 32'd9, 32'd9);
        drive_req(0, 3'b110, 32'd9, 32'd9);
      end
      begin
        drive_req(1, 3'b001, 32'hF0, 32'h0F);
        drive_req(1, 3'b001, 32'hF0, 32'h0F);
      end
    join
    wait_idle();
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 0; exp_order[3] = 1;
    for (int i = 0; i < 4; i++) begin
      if (grant_log.size() > base + i)
        check("tie_order", {31'd0, grant_log[base+i]}, exp_order[i]);
      else
        check("tie_order_missing", 32'd0, 32'd1);
    end

    // Back-pressure: SLT held in RESP, queued req0 waits.
    bus.rsp_ready = 1'b0;
    drive_req(0, 3'b111, 32'd3, 32'd8);
    fork
      drive_req(0, 3'b000, 32'hFF00, 32'h0FF0);
    join_none
    repeat (2) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("stall_data", bus.rsp_data, 32'd1);
      check("stall_no_grant", {31'd0, bus.req0_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("queued_grant", {31'd0, bus.req0_ready}, 32'd1);
    wait_idle();
    wait fork;
    @(posedge clk);
    #1;

    // Reset while in EXEC.
    drive_req(1, 3'b010, 32'd1, 32'd2);
    check("exec_alu_control", {29'd0, bus.alu_control}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
`ifdef ALU_ARB_PERF_EN
    check("midreset_perf0", {28'd0, perf_grant0}, 32'd0);
`endif
    sb.delete();
    m_busy = 1'b0;
    m_last = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) stale = 1'b1;
    end
    check("no_stale_rsp", {31'd0, stale}, 32'd0);
    @(posedge clk);
    #1;
    base = grant_log.size();
    fork
      drive_req(0, 3'b011, 32'hA5A5A5A5, 32'h5A5A5A5A);
      drive_req(1, 3'b010, 32'hFFFFFFFF, 32'd1);
    join
    wait_idle();
    if (grant_log.size() > base) check("post_reset_tie", {31'd0, grant_log[base]}, 32'd0);
    else check("post_reset_tie_missing", 32'd0, 32'd1);

`ifdef ALU_ARB_PERF_EN
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    check("perf_clr0", {28'd0, perf_grant0}, 32'd0);
    check("perf_clr1", {28'd0, perf_grant1}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      drive_req(0, 3'b010, i, 32'd1);
    end
    wait_idle();
    check("perf_sat0", {28'd0, perf_grant0}, 32'd15);
    check("perf_idle1", {28'd0, perf_grant1}, 32'd0);
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    check("perf_after_clr", {28'd0, perf_grant0}, 32'd0);
`endif

    check("alu_never_illegal", {31'd0, illegal_seen}, 32'd0);
    check("scoreboard_empty", sb.size(), 32'd0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
